// File: rtl/uart_tx_fifo.sv
// UART transmitter with input queue; configurable data bits, parity and stop bits.
// Latency: first START cycle begins one clock after the push edge when idle; queued frames follow with no gap.
// Backpressure: o_Tx_Ready low while the queue is full; a push while full is dropped and pulses o_Overflow.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 27,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_n,
    input  logic                        i_Tx_DV,
    input  logic [DATA_BITS-1:0]        i_Tx_Byte,
    output logic                        o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
    output logic                        o_Overflow,
    output logic                        o_Tx_Active,
    output logic                        o_Tx_Serial,
    output logic                        o_Tx_Done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [NW-1:0]        count;
    logic [DATA_BITS-1:0] head;

    state_t               state;
    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bit_end;
    logic last_stop;

    assign empty     = (count == '0);
    assign full      = (count == NW'(FIFO_DEPTH));
    assign push      = i_Tx_DV && !full;
    assign bit_end   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
    // Pop exactly when the FSM heads for START: from IDLE, or at the end of the final stop bit.
    assign pop       = !empty && ((state == S_IDLE) ||
                                  ((state == S_STOP) && bit_end && last_stop));
    assign head      = mem[rd_ptr];

    assign o_Tx_Ready   = !full;
    assign o_Fifo_Count = count;

    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= i_Tx_Byte;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_Overflow <= 1'b0;
        end else begin
            o_Overflow <= i_Tx_DV && full;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;
            if (pop) begin
                shreg       <= head;
                par_bit     <= (PARITY == 1) ? ~^head : ^head;
                state       <= S_START;
                clk_cnt     <= '0;
                stop_idx    <= 1'b0;
                o_Tx_Serial <= 1'b0;
                o_Tx_Active <= 1'b1;
                o_Tx_Done   <= (state == S_STOP);
            end else begin
                case (state)
                    S_IDLE: begin
                        o_Tx_Serial <= 1'b1;
                        o_Tx_Active <= 1'b0;
                        clk_cnt     <= '0;
                    end
                    S_START: begin
                        if (bit_end) begin
                            clk_cnt     <= '0;
                            bit_idx     <= '0;
                            o_Tx_Serial <= shreg[0];
                            state       <= S_DATA;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            clk_cnt <= '0;
                            if (bit_idx == BW'(DATA_BITS - 1)) begin
                                if (PARITY != 0) begin
                                    o_Tx_Serial <= par_bit;
                                    state       <= S_PARITY;
                                end else begin
                                    o_Tx_Serial <= 1'b1;
                                    stop_idx    <= 1'b0;
                                    state       <= S_STOP;
                                end
                            end else begin
                                bit_idx     <= bit_idx + 1'b1;
                                shreg       <= shreg >> 1;
                                o_Tx_Serial <= shreg[1];
                            end
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (bit_end) begin
                            clk_cnt     <= '0;
                            stop_idx    <= 1'b0;
                            o_Tx_Serial <= 1'b1;
                            state       <= S_STOP;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (bit_end) begin
                            clk_cnt <= '0;
                            if (last_stop) begin
                                o_Tx_Done   <= 1'b1;
                                o_Tx_Active <= 1'b0;
                                state       <= S_IDLE;
                            end else begin
                                stop_idx <= 1'b1;
                            end
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state       <= S_IDLE;
                        o_Tx_Serial <= 1'b1;
                        o_Tx_Active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Four transmitter configurations driven from one process; a per-cycle expected-line queue checks each.
module tb_uart_tx_fifo;

    typedef struct packed {
        logic ln;
        logic last;
    } exp_t;

    function automatic int cpb_of(int i);
        return (i == 3) ? 3 : 4;
    endfunction
    function automatic int dbits_of(int i);
        return (i == 3) ? 5 : 8;
    endfunction
    function automatic int par_of(int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 0);
    endfunction
    function automatic int stop_of(int i);
        return (i == 2) ? 2 : 1;
    endfunction

    logic       clk;
    logic       rst_n;
    logic       dv      [4];
    logic [8:0] tx_byte [4];
    logic       rdy     [4];
    logic [2:0] cnt     [4];
    logic       ovf     [4];
    logic       act     [4];
    logic       ser     [4];
    logic       done    [4];

    exp_t exp_q      [4][$];
    int   done_t     [4][$];
    logic prev_last  [4];
    int   act_cycles [4];
    int   cyc;
    int   errors;
    int   checks;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int CPB = cpb_of(g);
        localparam int DB  = dbits_of(g);
        localparam int PAR = par_of(g);
        localparam int SB  = stop_of(g);
        uart_tx_fifo #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS   (DB),
            .PARITY      (PAR),
            .STOP_BITS   (SB),
            .FIFO_DEPTH  (4)
        ) u_dut (
            .i_Clock     (clk),
            .i_Rst_n     (rst_n),
            .i_Tx_DV     (dv[g]),
            .i_Tx_Byte   (tx_byte[g][DB-1:0]),
            .o_Tx_Ready  (rdy[g]),
            .o_Fifo_Count(cnt[g]),
            .o_Overflow  (ovf[g]),
            .o_Tx_Active (act[g]),
            .o_Tx_Serial (ser[g]),
            .o_Tx_Done   (done[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(int i, logic [8:0] d);
        logic fr[$];
        int   ones;
        ones = 0;
        fr.push_back(1'b0);
        for (int k = 0; k < dbits_of(i); k++) begin
            fr.push_back(d[k]);
            ones += int'(d[k]);
        end
        if (par_of(i) == 1) fr.push_back((ones % 2) == 0);
        else if (par_of(i) == 2) fr.push_back((ones % 2) == 1);
        for (int k = 0; k < stop_of(i); k++) fr.push_back(1'b1);
        for (int k = 0; k < fr.size(); k++) begin
            for (int c = 0; c < cpb_of(i); c++) begin
                exp_q[i].push_back('{ln: fr[k], last: (k == fr.size() - 1) && (c == cpb_of(i) - 1)});
            end
        end
    endtask

    task automatic monitor_all();
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            logic now_last;
            now_last = 1'b0;
            if (!rst_n) begin
                prev_last[i] = 1'b0;
            end else begin
                check($sformatf("done%0d", i), done[i], prev_last[i]);
                if (done[i]) done_t[i].push_back(cyc);
                if (act[i]) begin
                    act_cycles[i]++;
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("spurious_frame%0d", i), act[i], 0);
                    end else begin
                        e = exp_q[i].pop_front();
                        check($sformatf("line%0d", i), ser[i], e.ln);
                        now_last = e.last;
                    end
                end else begin
                    check($sformatf("idle_line%0d", i), ser[i], 1);
                    if (prev_last[i] && exp_q[i].size() != 0)
                        check($sformatf("gap_active%0d", i), act[i], 1);
                end
                prev_last[i] = now_last;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor_all();
    endtask

    function automatic logic all_idle();
        logic r;
        r = 1'b1;
        for (int i = 0; i < 4; i++) if (act[i] || exp_q[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(int maxc);
        int n;
        n = 0;
        while (n < maxc && !all_idle()) begin
            tick();
            n++;
        end
        check("idle_timeout", all_idle(), 1);
    endtask

    task automatic push_byte(int i, logic [8:0] d, logic accept);
        dv[i]      = 1'b1;
        tx_byte[i] = d;
        if (accept) push_frame(i, d);
        tick();
        dv[i]      = 1'b0;
        tx_byte[i] = 9'($urandom);
    endtask

    initial begin
        int base;
        int cnt_exp[6];
        cnt_exp = '{1, 1, 2, 3, 4, 4};
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dv[i] = 1'b0; tx_byte[i] = '0; prev_last[i] = 1'b0; act_cycles[i] = 0;
        end
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            check("rst_serial", ser[i], 1);
            check("rst_active", act[i], 0);
            check("rst_done", done[i], 0);
            check("rst_ovf", ovf[i], 0);
            check("rst_count", cnt[i], 0);
            check("rst_ready", rdy[i], 1);
        end
        rst_n = 1'b1;
        repeat (2) tick();

        // 0xA5, even parity, one stop bit
        base = act_cycles[0]; done_t[0].delete();
        push_byte(0, 9'h0A5, 1'b1);
        wait_idle(200);
        check("t1_active_cycles", act_cycles[0] - base, 44);
        check("t1_done_pulses", done_t[0].size(), 1);

        // parity bit for 0x01 and 0x00 under even and odd
        done_t[0].delete(); done_t[1].delete();
        push_byte(0, 9'h001, 1'b1);
        push_byte(1, 9'h001, 1'b1);
        push_byte(0, 9'h000, 1'b1);
        push_byte(1, 9'h000, 1'b1);
        wait_idle(300);
        check("t2_done_even", done_t[0].size(), 2);
        check("t2_done_odd", done_t[1].size(), 2);

        // three back-to-back frames with two stop bits
        base = act_cycles[2]; done_t[2].delete();
        push_byte(2, 9'h011, 1'b1);
        push_byte(2, 9'h022, 1'b1);
        push_byte(2, 9'h033, 1'b1);
        wait_idle(400);
        check("t3_active_cycles", act_cycles[2] - base, 132);
        check("t3_done_pulses", done_t[2].size(), 3);
        if (done_t[2].size() == 3) begin
            check("t3_done_gap1", done_t[2][1] - done_t[2][0], 44);
            check("t3_done_gap2", done_t[2][2] - done_t[2][1], 44);
        end

        // six pushes into a depth-4 queue
        done_t[0].delete();
        for (int k = 0; k < 6; k++) begin
            push_byte(0, 9'(8'h10 + k), k < 5);
            check($sformatf("t4_count%0d", k), cnt[0], cnt_exp[k]);
            check($sformatf("t4_active%0d", k), act[0], k > 0);
            check($sformatf("t4_ready%0d", k), rdy[0], cnt_exp[k] != 4);
            check($sformatf("t4_ovf%0d", k), ovf[0], k == 5);
        end
        tick();
        check("t4_ovf_pulse_end", ovf[0], 0);
        wait_idle(600);
        check("t4_frames", done_t[0].size(), 5);

        // 5 data bits; upper input bits must be ignored
        base = act_cycles[3]; done_t[3].delete();
        push_byte(3, 9'h1B6, 1'b1);
        wait_idle(100);
        check("t5_active_cycles", act_cycles[3] - base, 21);
        check("t5_done_pulses", done_t[3].size(), 1);

        // reset mid-DATA with two more frames queued
        push_byte(0, 9'h03C, 1'b1);
        push_byte(0, 9'h05A, 1'b1);
        push_byte(0, 9'h096, 1'b1);
        repeat (12) tick();
        check("t6_pre_active", act[0], 1);
        check("t6_pre_count", cnt[0], 2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_serial", ser[0], 1);
        check("t6_async_active", act[0], 0);
        check("t6_async_count", cnt[0], 0);
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        tick();
        tick();
        rst_n = 1'b1;
        done_t[0].delete();
        repeat (60) tick();
        check("t6_post_count", cnt[0], 0);
        check("t6_post_active", act[0], 0);
        check("t6_post_done", done_t[0].size(), 0);
        push_byte(0, 9'h0C3, 1'b1);
        wait_idle(200);
        check("t6_new_frame", done_t[0].size(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, the successor to our fixed 8N1 transmitter. Adds:
- configurable data width, parity and stop-bit count;
- an input FIFO so the host can queue bytes;
- back-to-back framing with no idle gap between queued frames;
- asynchronous active-low reset.

It sits between the host/control logic and the board serial pin.

Parameters:
CLKS_PER_BIT, 27, i_Clock cycles per serial bit (>=2); e.g. 25 MHz / 921600 baud = 27
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, queue entries, power of 2, >=2

Ports:
i_Clock  in  1  system clock, all logic on rising edge
i_Rst_n  in  1  asynchronous active-low reset
i_Tx_DV  in  1  push strobe; i_Tx_Byte is written when high and FIFO not full
i_Tx_Byte  in  DATA_BITS  data to queue
o_Tx_Ready  out  1  FIFO not full (combinational from count)
o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  entries queued, 0..FIFO_DEPTH
o_Overflow  out  1  1-cycle pulse when i_Tx_DV arrives while FIFO full; the byte is dropped
o_Tx_Active  out  1  high while a frame is on the line
o_Tx_Serial  out  1  serial line, idle high
o_Tx_Done  out  1  1-cycle pulse after each frame's final stop bit

Behaviour:
- Reset (i_Rst_n low, async):
  - outputs: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0;
  - internal: FIFO pointers and count=0, state IDLE, counters 0.
  - Reset mid-frame aborts the frame; the line goes high immediately and queued data is lost.
- FIFO:
  - Push on rising edge when i_Tx_DV && count<FIFO_DEPTH.
  - Pop on the edge the state machine leaves IDLE or STOP toward START.
  - Simultaneous push and pop: count unchanged, both take effect. A push when full is dropped even if a pop occurs on the same edge.
  - Pointers wrap modulo FIFO_DEPTH.
- Bit counter width is $clog2(CLKS_PER_BIT). Every bit period, including parity and each stop bit, is exactly CLKS_PER_BIT cycles.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_Tx_Serial=1.
  - If FIFO non-empty: pop the head into the shift register, compute the parity bit, go to START, set o_Tx_Active=1.
  - Registered output: the line goes low on the first START cycle, i.e. 1 cycle after IDLE sees non-empty.
- START: line 0 for CLKS_PER_BIT cycles -> DATA.
- DATA:
  - line = data[bit_index], for DATA_BITS bits in order 0..DATA_BITS-1.
  - After the last bit: -> PARITY if PARITY!=0, else -> STOP.
- PARITY:
  - odd: bit = ~^data; even: bit = ^data.
  - Hold 1 bit period -> STOP.
- STOP:
  - line 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle, o_Tx_Done is registered high for exactly 1 cycle.
  - If FIFO non-empty: pop and go straight to START. o_Tx_Active stays 1 and there is no idle gap.
  - Else: -> IDLE, o_Tx_Active=0.
- Frame length: (1+DATA_BITS+(PARITY?1:0)+STOP_BITS)*CLKS_PER_BIT cycles.
- Data is captured at pop, so i_Tx_Byte may change after the push edge.
- Illegal/unused state encodings return to IDLE with the line high.

Test Plan:
1. CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2, STOP_BITS=1; push 0xA5.
   Required: line shows 0, 1,0,1,0,0,1,0,1, parity 0, 1 (each bit 4 cycles, 44 cycles total). o_Tx_Done pulses once. o_Tx_Active is high for exactly 44 cycles.
2. Parity check with 0x01: PARITY=1 gives parity bit 0; PARITY=2 gives parity bit 1. With 0x00: odd gives 1, even gives 0.
3. PARITY=0, STOP_BITS=2; push 0x11, 0x22, 0x33 on consecutive cycles.
   Required: three 44-cycle frames contiguous (132 cycles) with no high gap beyond the stop bits. o_Tx_Active stays high throughout. 3 o_Tx_Done pulses, 44 cycles apart.
4. FIFO_DEPTH=4, idle, empty; push 6 bytes on 6 consecutive cycles.
   Required: the first is popped 1 cycle after its push. count reaches 4 after the 5th push. The 6th raises o_Overflow for 1 cycle and o_Tx_Ready=0. Exactly 5 frames are sent, in order.
5. DATA_BITS=5, PARITY=0, STOP_BITS=1, CLKS_PER_BIT=3; push 5'b10110.
   Required: 0, 0,1,1,0,1, 1 over 21 cycles. Bits above DATA_BITS do not exist.
6. Assert i_Rst_n low mid-DATA of a frame with 2 more bytes queued.
   Required: o_Tx_Serial=1 and o_Tx_Active=0 without waiting for a clock. After release, count=0 and no frame is sent until a new push.
